rv_decode_stage: RTL and testbench
==================================

# rv_decode_stage

Registered, parametrised RV32I/M instruction decode stage between fetch and execute. It turns a fetched instruction into ALU and memory/branch control signals plus register indices and a sign-extended immediate. A two-entry skid buffer with valid/ready handshakes on both sides decouples fetch from execute. The block adds M-extension decode, illegal-instruction detection, flush support and a saturating illegal-instruction counter.

## Interface
Parameters:
- XLEN, 32: width of pc and imm; legal values 32 or 64. Decode is always RV32 encoding.
- EN_M, 1: 1 decodes the M extension; 0 flags M encodings as illegal.
- CNT_W, 16: width of the illegal-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered instructions.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage can accept; equals "skid entry empty".
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  execute accepts.
- out_pc  out  XLEN  pc of the decoded entry.
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20].
- out_imm  out  XLEN  immediate, sign-extended to XLEN.
- out_alu_ctrl  out  5  ALU operation.
- out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_alu_src, out_branch, out_jump  out  1 each  control signals.
- out_funct3  out  3  passed through for load/store size and branch condition.
- out_illegal  out  1  entry is an illegal instruction.
- illegal_count  out  CNT_W  saturating count of illegal instructions accepted.

## Operation
- ALU codes:
  - 00000 AND, 00001 OR, 00010 ADD, 00011 XOR, 00100 SLL, 00101 SRL, 00110 SUB, 00111 SRA.
  - 01000 SLT, 01001 SLTU, 01010 LUI, 01011 AUIPC.
  - 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
- OP 0110011: reg_write=1.
  - funct7 0000000 with any funct3 gives the base ops. funct7 0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
  - funct7 0000001 with EN_M=1 gives M ops, in funct3 order MUL..REMU.
  - Any other funct7 is illegal.
- OP-IMM 0010011: reg_write=1, alu_src=1, I-immediate.
  - SLLI requires funct7=0000000.
  - funct3 101 requires funct7 0000000 (SRLI) or 0100000 (SRAI).
  - Any other funct7 on these shifts is illegal.
- LOAD 0000011: reg_write, mem_read, mem_to_reg and alu_src all 1; ADD. funct3 011, 110 and 111 are illegal.
- STORE 0100011: mem_write=1, alu_src=1; ADD; S-immediate. funct3 must be 000, 001 or 010, otherwise illegal.
- BRANCH 1100011: branch=1; B-immediate.
  - ALU op: BEQ/BNE use SUB, BLT/BGE use SLT, BLTU/BGEU use SLTU.
  - funct3 010 and 011 are illegal.
- JAL 1101111: reg_write=1, jump=1, ADD, J-immediate.
- JALR 1100111: reg_write=1, jump=1, alu_src=1, ADD, I-immediate. funct3 must be 000, otherwise illegal.
- LUI 0110111: reg_write=1, LUI, U-immediate. AUIPC 0010111: reg_write=1, AUIPC, U-immediate.
- Any other opcode, or instr[1:0]≠11, is illegal.
- Illegal entries still flow through the stage:
  - out_illegal=1.
  - reg_write, mem_read, mem_write, mem_to_reg, branch, jump all 0; alu_ctrl=00000.
  - pc and the raw field outputs still pass through.
- illegal_count increments by 1 on every accepted illegal instruction. It saturates at all-ones and is not cleared by flush.

## Timing
- Reset:
  - out_valid=0, skid empty, so in_ready=1.
  - All out_* payload signals 0, including out_illegal=0.
  - illegal_count=0.
- Input handshake: in_valid&&in_ready. Output handshake: out_valid&&out_ready.
- Latency: an instruction accepted in cycle N appears at the output in cycle N+1, provided the output register is empty or firing in cycle N.
- Stall behaviour:
  - If the output register is occupied and not firing, an accepted instruction goes to the skid entry; in_ready=0 from the next cycle.
  - When the output fires with the skid entry full, skid moves to output, and in_ready=1 in the next cycle.
- Ordering is strictly FIFO. Payload is stable while out_valid&&!out_ready.
- Decode is combinational on in_instr. Both entries store fully decoded payload.
- Flush:
  - Out_valid and the skid entry clear next cycle.
  - An input handshake in the flush cycle is dropped and is not counted.
  - The output handshake in the flush cycle still completes.
- rst has priority over flush. Reset mid-stream drops both entries.

## Test plan
- Reset, then ADD x3,x1,x2 (0x002081B3) with out_ready=1 → out_valid in the next cycle; alu_ctrl=00010, reg_write=1, rd=3, rs1=1, rs2=2.
- With EN_M=1, DIVU x5,x6,x7 (0x027352B3) → alu_ctrl=10101. With EN_M=0, the same instruction → out_illegal=1, reg_write=0, illegal_count=1.
- Hold out_ready=0 and send 3 instructions → first in output, second in skid, in_ready=0, third waits. Raise out_ready → all 3 emerge in order, one per cycle.
- Flush with both entries full and in_valid=1 → out_valid=0 and in_ready=1 in the next cycle; no instruction from before the flush appears.
- Sign extension: LW x1,-4(x2) (0xFFC12083) with XLEN=64 → out_imm=0xFFFFFFFFFFFFFFFC, mem_read=1, mem_to_reg=1. SRAI with funct7=0100001 → out_illegal=1.
- Saturation: CNT_W=2, send 5 illegal words (0x00000000) → illegal_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/rv_decode_stage.sv
// RV32I/M decode stage: combinational decode into a two-entry (output + skid)
// valid/ready buffer, with flush and a saturating illegal-instruction counter.
module rv_decode_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned EN_M  = 1,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [XLEN-1:0]  out_imm,
   output logic [4:0]       out_alu_ctrl,
   output logic             out_reg_write,
   output logic             out_mem_read,
   output logic             out_mem_write,
   output logic             out_mem_to_reg,
   output logic             out_alu_src,
   output logic             out_branch,
   output logic             out_jump,
   output logic [2:0]       out_funct3,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_count
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   localparam logic [4:0] ALU_AND   = 5'b00000;
   localparam logic [4:0] ALU_OR    = 5'b00001;
   localparam logic [4:0] ALU_ADD   = 5'b00010;
   localparam logic [4:0] ALU_XOR   = 5'b00011;
   localparam logic [4:0] ALU_SLL   = 5'b00100;
   localparam logic [4:0] ALU_SRL   = 5'b00101;
   localparam logic [4:0] ALU_SUB   = 5'b00110;
   localparam logic [4:0] ALU_SRA   = 5'b00111;
   localparam logic [4:0] ALU_SLT   = 5'b01000;
   localparam logic [4:0] ALU_SLTU  = 5'b01001;
   localparam logic [4:0] ALU_LUI   = 5'b01010;
   localparam logic [4:0] ALU_AUIPC = 5'b01011;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
      logic [4:0]      alu_ctrl;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            mem_to_reg;
      logic            alu_src;
      logic            branch;
      logic            jump;
      logic [2:0]      funct3;
      logic            illegal;
   } dec_t;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   dec_t            dec;
   logic            ill;

   dec_t             out_q, out_d, skid_q, skid_d;
   logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_fire, out_free;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];

   assign imm_i = XLEN'($signed(in_instr[31:20]));
   assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
   assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

   // Instruction decode; illegal encodings keep raw fields but lose all side effects.
   always_comb begin
      dec        = '0;
      ill        = 1'b0;
      dec.pc     = in_pc;
      dec.rd     = in_instr[11:7];
      dec.rs1    = in_instr[19:15];
      dec.rs2    = in_instr[24:20];
      dec.funct3 = funct3;
      case (opcode)
         OPC_OP: begin
            dec.reg_write = 1'b1;
            case (funct7)
               F7_BASE: begin
                  case (funct3)
                     3'b000:  dec.alu_ctrl = ALU_ADD;
                     3'b001:  dec.alu_ctrl = ALU_SLL;
                     3'b010:  dec.alu_ctrl = ALU_SLT;
                     3'b011:  dec.alu_ctrl = ALU_SLTU;
                     3'b100:  dec.alu_ctrl = ALU_XOR;
                     3'b101:  dec.alu_ctrl = ALU_SRL;
                     3'b110:  dec.alu_ctrl = ALU_OR;
                     default: dec.alu_ctrl = ALU_AND;
                  endcase
               end
               F7_ALT: begin
                  if (funct3 == 3'b000)      dec.alu_ctrl = ALU_SUB;
                  else if (funct3 == 3'b101) dec.alu_ctrl = ALU_SRA;
                  else                       ill = 1'b1;
               end
               F7_MUL: begin
                  if (EN_M != 0) dec.alu_ctrl = {2'b10, funct3};
                  else           ill = 1'b1;
               end
               default: ill = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm       = imm_i;
            case (funct3)
               3'b000: dec.alu_ctrl = ALU_ADD;
               3'b010: dec.alu_ctrl = ALU_SLT;
               3'b011: dec.alu_ctrl = ALU_SLTU;
               3'b100: dec.alu_ctrl = ALU_XOR;
               3'b110: dec.alu_ctrl = ALU_OR;
               3'b111: dec.alu_ctrl = ALU_AND;
               3'b001: begin
                  if (funct7 == F7_BASE) dec.alu_ctrl = ALU_SLL;
                  else                   ill = 1'b1;
               end
               default: begin
                  if (funct7 == F7_BASE)     dec.alu_ctrl = ALU_SRL;
                  else if (funct7 == F7_ALT) dec.alu_ctrl = ALU_SRA;
                  else                       ill = 1'b1;
               end
            endcase
         end
         OPC_LOAD: begin
            dec.reg_write  = 1'b1;
            dec.mem_read   = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.alu_src    = 1'b1;
            dec.alu_ctrl   = ALU_ADD;
            dec.imm        = imm_i;
            ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OPC_STORE: begin
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_ctrl  = ALU_ADD;
            dec.imm       = imm_s;
            ill = (funct3[2] == 1'b1) || (funct3 == 3'b011);
         end
         OPC_BRANCH: begin
            dec.branch = 1'b1;
            dec.imm    = imm_b;
            case (funct3[2:1])
               2'b00:   dec.alu_ctrl = ALU_SUB;
               2'b10:   dec.alu_ctrl = ALU_SLT;
               2'b11:   dec.alu_ctrl = ALU_SLTU;
               default: ill = 1'b1;
            endcase
         end
         OPC_JAL: begin
            dec.reg_write = 1'b1;
            dec.jump      = 1'b1;
            dec.alu_ctrl  = ALU_ADD;
            dec.imm       = imm_j;
         end
         OPC_JALR: begin
            dec.reg_write = 1'b1;
            dec.jump      = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_ctrl  = ALU_ADD;
            dec.imm       = imm_i;
            ill = (funct3 != 3'b000);
         end
         OPC_LUI: begin
            dec.reg_write = 1'b1;
            dec.alu_ctrl  = ALU_LUI;
            dec.imm       = imm_u;
         end
         OPC_AUIPC: begin
            dec.reg_write = 1'b1;
            dec.alu_ctrl  = ALU_AUIPC;
            dec.imm       = imm_u;
         end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         dec.illegal    = 1'b1;
         dec.alu_ctrl   = ALU_AND;
         dec.reg_write  = 1'b0;
         dec.mem_read   = 1'b0;
         dec.mem_write  = 1'b0;
         dec.mem_to_reg = 1'b0;
         dec.alu_src    = 1'b0;
         dec.branch     = 1'b0;
         dec.jump       = 1'b0;
      end
   end

   assign in_fire  = in_valid && !skid_valid_q && !flush;
   assign out_free = !out_valid_q || out_ready;

   // Buffer next state: output slot refills from skid first to keep FIFO order.
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      cnt_d        = cnt_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_free) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            out_d       = dec;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
      if (in_fire && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         cnt_q        <= cnt_d;
      end
   end

   assign in_ready       = !skid_valid_q;
   assign out_valid      = out_valid_q;
   assign out_pc         = out_q.pc;
   assign out_rd         = out_q.rd;
   assign out_rs1        = out_q.rs1;
   assign out_rs2        = out_q.rs2;
   assign out_imm        = out_q.imm;
   assign out_alu_ctrl   = out_q.alu_ctrl;
   assign out_reg_write  = out_q.reg_write;
   assign out_mem_read   = out_q.mem_read;
   assign out_mem_write  = out_q.mem_write;
   assign out_mem_to_reg = out_q.mem_to_reg;
   assign out_alu_src    = out_q.alu_src;
   assign out_branch     = out_q.branch;
   assign out_jump       = out_q.jump;
   assign out_funct3     = out_q.funct3;
   assign out_illegal    = out_q.illegal;
   assign illegal_count  = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: instance A (XLEN=64, M on) and
// instance B (XLEN=32, M off, 2-bit counter), directed vectors.
module tb_rv_decode_stage;

   typedef struct packed {
      logic [63:0] pc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [63:0] imm;
      logic [4:0]  alu;
      logic [7:0]  ctl;   // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, illegal}
      logic [2:0]  f3;
   } exp_t;

   logic clk;
   int   checks = 0;
   int   errors = 0;
   exp_t qa[$];
   exp_t qb[$];

   logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0] a_in_instr;
   logic [63:0] a_in_pc, a_out_pc, a_out_imm;
   logic [4:0]  a_rd, a_rs1, a_rs2, a_alu;
   logic        a_rw, a_mr, a_mw, a_m2r, a_asrc, a_br, a_jmp, a_ill;
   logic [2:0]  a_f3;
   logic [15:0] a_cnt;

   logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0] b_in_instr, b_in_pc, b_out_pc, b_out_imm;
   logic [4:0]  b_rd, b_rs1, b_rs2, b_alu;
   logic        b_rw, b_mr, b_mw, b_m2r, b_asrc, b_br, b_jmp, b_ill;
   logic [2:0]  b_f3;
   logic [1:0]  b_cnt;

   rv_decode_stage #(.XLEN(64), .EN_M(1), .CNT_W(16)) u_a (
      .clk(clk), .rst(a_rst), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
      .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_imm(a_out_imm),
      .out_alu_ctrl(a_alu), .out_reg_write(a_rw), .out_mem_read(a_mr), .out_mem_write(a_mw),
      .out_mem_to_reg(a_m2r), .out_alu_src(a_asrc), .out_branch(a_br), .out_jump(a_jmp),
      .out_funct3(a_f3), .out_illegal(a_ill), .illegal_count(a_cnt)
   );

   rv_decode_stage #(.XLEN(32), .EN_M(0), .CNT_W(2)) u_b (
      .clk(clk), .rst(b_rst), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
      .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_imm(b_out_imm),
      .out_alu_ctrl(b_alu), .out_reg_write(b_rw), .out_mem_read(b_mr), .out_mem_write(b_mw),
      .out_mem_to_reg(b_m2r), .out_alu_src(b_asrc), .out_branch(b_br), .out_jump(b_jmp),
      .out_funct3(b_f3), .out_illegal(b_ill), .illegal_count(b_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [63:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [63:0] imm, input logic [4:0] alu,
                               input logic [7:0] ctl, input logic [2:0] f3);
      exp_t e;
      e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
      e.alu = alu; e.ctl = ctl; e.f3 = f3;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitors: pop one expected entry per output handshake.
   always @(negedge clk) begin
      exp_t act, e;
      if (!a_rst && a_out_valid && a_out_ready) begin
         act = '{a_out_pc, a_rd, a_rs1, a_rs2, a_out_imm, a_alu,
                 {a_rw, a_mr, a_mw, a_m2r, a_asrc, a_br, a_jmp, a_ill}, a_f3};
         checks++;
         if (qa.size() == 0) begin
            errors++;
            $display("FAIL a_unexpected_out: got %h expected none", act);
         end else begin
            e = qa.pop_front();
            if (act !== e) begin
               errors++;
               $display("FAIL a_out pc=%0h: got %h expected %h", e.pc, act, e);
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t act, e;
      if (!b_rst && b_out_valid && b_out_ready) begin
         act = '{64'(b_out_pc), b_rd, b_rs1, b_rs2, 64'(b_out_imm), b_alu,
                 {b_rw, b_mr, b_mw, b_m2r, b_asrc, b_br, b_jmp, b_ill}, b_f3};
         checks++;
         if (qb.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected_out: got %h expected none", act);
         end else begin
            e = qb.pop_front();
            if (act !== e) begin
               errors++;
               $display("FAIL b_out pc=%0h: got %h expected %h", e.pc, act, e);
            end
         end
      end
   end

   // Offer one instruction; called at posedge+1, returns at posedge+1 after acceptance.
   task automatic send(input bit on_b, input logic [31:0] instr, input exp_t e);
      bit rdy;
      int n;
      if (on_b) begin
         b_in_valid = 1'b1; b_in_instr = instr; b_in_pc = e.pc[31:0];
      end else begin
         a_in_valid = 1'b1; a_in_instr = instr; a_in_pc = e.pc;
      end
      n = 0;
      do begin
         @(negedge clk);
         rdy = on_b ? b_in_ready : a_in_ready;
         @(posedge clk);
         n++;
      end while (!rdy && n < 100);
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL send_timeout instr=%h: got in_ready=0 expected 1", instr);
      end else if (on_b) qb.push_back(e);
      else               qa.push_back(e);
      #1;
      if (on_b) b_in_valid = 1'b0;
      else      a_in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_instr = '0; a_in_pc = '0; a_out_ready = 1'b1;
      b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_instr = '0; b_in_pc = '0; b_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      a_rst = 1'b0; b_rst = 1'b0;

      @(negedge clk);
      chk("rst_out_valid", 64'(a_out_valid), 64'd0);
      chk("rst_in_ready", 64'(a_in_ready), 64'd1);
      chk("rst_pc", a_out_pc, 64'd0);
      chk("rst_imm", a_out_imm, 64'd0);
      chk("rst_fields", 64'({a_rd, a_rs1, a_rs2, a_alu, a_rw, a_mr, a_mw, a_m2r, a_asrc,
                            a_br, a_jmp, a_f3, a_ill}), 64'd0);
      chk("rst_cnt", 64'(a_cnt), 64'd0);
      @(posedge clk); #1;

      // Streaming decode with execute always ready
      send(0, 32'h002081B3, mk(64'h1000, 3, 1, 2, 64'h0, 5'b00010, 8'h80, 3'd0));
      chk("add_latency_valid", 64'(a_out_valid), 64'd1);
      send(0, 32'h402081B3, mk(64'h1004, 3, 1, 2, 64'h0, 5'b00110, 8'h80, 3'd0));
      send(0, 32'h027352B3, mk(64'h1008, 5, 6, 7, 64'h0, 5'b10101, 8'h80, 3'd5));
      send(0, 32'hFFC12083, mk(64'h100C, 1, 2, 28, 64'hFFFF_FFFF_FFFF_FFFC, 5'b00010, 8'hD8, 3'd2));
      send(0, 32'h40335293, mk(64'h1010, 5, 6, 3, 64'h403, 5'b00111, 8'h88, 3'd5));
      send(0, 32'h42335293, mk(64'h1014, 5, 6, 3, 64'h423, 5'b00000, 8'h01, 3'd5));
      send(0, 32'h0020A423, mk(64'h1018, 8, 1, 2, 64'h8, 5'b00010, 8'h28, 3'd2));
      send(0, 32'hFE20CCE3, mk(64'h101C, 25, 1, 2, 64'hFFFF_FFFF_FFFF_FFF8, 5'b01000, 8'h04, 3'd4));
      send(0, 32'h001000EF, mk(64'h1020, 1, 0, 1, 64'h800, 5'b00010, 8'h82, 3'd0));
      send(0, 32'h800003B7, mk(64'h1024, 7, 0, 0, 64'hFFFF_FFFF_8000_0000, 5'b01010, 8'h80, 3'd0));
      send(0, 32'h000010E7, mk(64'h1028, 1, 0, 0, 64'h0, 5'b00000, 8'h01, 3'd1));
      send(0, 32'h00001197, mk(64'h102C, 3, 0, 0, 64'h1000, 5'b01011, 8'h80, 3'd1));
      send(0, 32'h002081B1, mk(64'h1030, 3, 1, 2, 64'h0, 5'b00000, 8'h01, 3'd0));
      send(0, 32'h202081B3, mk(64'h1034, 3, 1, 2, 64'h0, 5'b00000, 8'h01, 3'd0));
      send(0, 32'h000080E7, mk(64'h1038, 1, 1, 0, 64'h0, 5'b00010, 8'h8A, 3'd0));
      @(posedge clk); #1;
      chk("a_cnt_after_stream", 64'(a_cnt), 64'd4);

      // Stall: first to output, second to skid, third waits
      a_out_ready = 1'b0;
      send(0, 32'h002081B3, mk(64'h2000, 3, 1, 2, 64'h0, 5'b00010, 8'h80, 3'd0));
      send(0, 32'h402081B3, mk(64'h2004, 3, 1, 2, 64'h0, 5'b00110, 8'h80, 3'd0));
      a_in_valid = 1'b1; a_in_instr = 32'h00001197; a_in_pc = 64'h2008;
      @(negedge clk);
      chk("stall_in_ready", 64'(a_in_ready), 64'd0);
      chk("stall_out_valid", 64'(a_out_valid), 64'd1);
      chk("stall_out_pc", a_out_pc, 64'h2000);
      @(posedge clk); #1;
      a_out_ready = 1'b1;
      send(0, 32'h00001197, mk(64'h2008, 3, 0, 0, 64'h1000, 5'b01011, 8'h80, 3'd1));
      repeat (3) @(posedge clk);
      #1;
      chk("stall_drained", 64'(qa.size()), 64'd0);

      // Flush with both entries full and a pending illegal input
      a_out_ready = 1'b0;
      send(0, 32'h002081B3, mk(64'h3000, 3, 1, 2, 64'h0, 5'b00010, 8'h80, 3'd0));
      send(0, 32'h402081B3, mk(64'h3004, 3, 1, 2, 64'h0, 5'b00110, 8'h80, 3'd0));
      a_in_valid = 1'b1; a_in_instr = 32'h0000_0000; a_in_pc = 64'h3008;
      a_flush = 1'b1;
      @(posedge clk); #1;
      a_flush = 1'b0; a_in_valid = 1'b0;
      qa.delete();
      chk("flush_out_valid", 64'(a_out_valid), 64'd0);
      chk("flush_in_ready", 64'(a_in_ready), 64'd1);
      a_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("flush_cnt_unchanged", 64'(a_cnt), 64'd4);
      send(0, 32'h800003B7, mk(64'h3010, 7, 0, 0, 64'hFFFF_FFFF_8000_0000, 5'b01010, 8'h80, 3'd0));

      // Instance B: M disabled, then counter saturation
      send(1, 32'h027352B3, mk(64'h40, 5, 6, 7, 64'h0, 5'b00000, 8'h01, 3'd5));
      chk("b_divu_cnt", 64'(b_cnt), 64'd1);
      @(posedge clk); #1;
      b_rst = 1'b1;
      @(posedge clk); #1;
      b_rst = 1'b0;
      chk("b_rst_cnt", 64'(b_cnt), 64'd0);
      for (int i = 0; i < 5; i++) begin
         send(1, 32'h0000_0000, mk(64'h50 + 64'(4 * i), 0, 0, 0, 64'h0, 5'b00000, 8'h01, 3'd0));
         chk($sformatf("b_sat_cnt_%0d", i), 64'(b_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
      end

      repeat (5) @(posedge clk);
      #1;
      chk("qa_drained", 64'(qa.size()), 64'd0);
      chk("qb_drained", 64'(qb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
